// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-control defaults and the next-PC controller state type
package cpu_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} npc_state_t;
endpackage

// File: rtl/stall_watchdog.sv
// stall_watchdog: saturating consecutive-stall counter with a sticky timeout flag
module stall_watchdog #(
    parameter int STALL_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    output logic timeout
);
    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;
    always_comb begin
        cnt_d = stall ? ((cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1) : 8'd0;
        to_d  = to_q | (stall & (cnt_q == 8'(STALL_MAX - 1)));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
    assign timeout = to_q;
endmodule

// File: rtl/f_npc_ctrl.sv
// f_npc_ctrl: next-PC priority mux and fetch enable with stalled-redirect holding
module f_npc_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
    parameter int          STALL_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output logic        we,
    output logic        pend,
    output logic        misalign,
    output logic        stall_timeout
);
    npc_state_t  state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic        mis_q, mis_d;
    logic        we_run;
    always_comb begin
        we_run  = ~stall | exc_req | eret_req;
        // Any accepted write consumes or cancels the held redirect; a stalled branch (re)loads it.
        state_d = we_run ? IDLE : (br_valid ? PEND : state_q);
        tgt_d   = (~we_run & br_valid) ? br_target : tgt_q;
        npc     = reset    ? RESET_PC :
                  exc_req  ? EXC_VEC  :
                  eret_req ? epc      :
                  (state_q == PEND) ? tgt_q :
                  br_valid ? br_target : pc_f + 32'd4;
        we      = we_run & ~reset;
        mis_d   = we ? (npc[1] | npc[0]) : mis_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            mis_q   <= mis_d;
        end
    end
    assign pend     = (state_q == PEND);
    assign misalign = mis_q;
    stall_watchdog #(.STALL_MAX(STALL_MAX)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .timeout (stall_timeout)
    );
endmodule

// File: tb/tb_f_npc_ctrl.sv
// tb_f_npc_ctrl: directed plus random stimulus against a behavioural model, scoreboard-checked
module tb_f_npc_ctrl;
    localparam int          SMAX = 16;
    localparam logic [31:0] RPC  = 32'h0000_3000;
    localparam logic [31:0] EVEC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset, stall, br_valid, exc_req, eret_req;
    logic [31:0] pc_f, br_target, epc, npc;
    logic        we, pend, misalign, stall_timeout;

    typedef struct {
        logic [31:0] npc;
        logic        we, pend, mis, to;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   total = 0, passed = 0;

    // Behavioural model: a held redirect, last accepted alignment, length of the current stall run.
    bit          m_pend, m_mis, m_to;
    logic [31:0] m_tgt;
    int          m_run;

    always #5 clk = ~clk;

    f_npc_ctrl dut (
        .clk(clk), .reset(reset), .pc_f(pc_f), .stall(stall),
        .br_valid(br_valid), .br_target(br_target), .exc_req(exc_req),
        .eret_req(eret_req), .epc(epc), .npc(npc), .we(we), .pend(pend),
        .misalign(misalign), .stall_timeout(stall_timeout)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            check("npc", npc, e_mon.npc);
            check("we", {31'd0, we}, {31'd0, e_mon.we});
            check("pend", {31'd0, pend}, {31'd0, e_mon.pend});
            check("misalign", {31'd0, misalign}, {31'd0, e_mon.mis});
            check("stall_timeout", {31'd0, stall_timeout}, {31'd0, e_mon.to});
        end
    end

    task automatic cyc(input bit r, input bit st, input bit bv, input bit ex, input bit er,
                       input logic [31:0] bt, input logic [31:0] ep, input logic [31:0] pc);
        exp_t e;
        reset = r; stall = st; br_valid = bv; exc_req = ex; eret_req = er;
        br_target = bt; epc = ep; pc_f = pc;
        e.we   = !r && (!st || ex || er);
        e.npc  = r ? RPC : ex ? EVEC : er ? ep : m_pend ? m_tgt : bv ? bt : pc + 32'd4;
        e.pend = m_pend;
        e.mis  = m_mis;
        e.to   = m_to;
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_tgt = 0; m_mis = 0; m_to = 0; m_run = 0;
        end else begin
            if (e.we) begin
                m_pend = 0;
                m_mis  = (e.npc % 4) != 0;
            end else if (bv) begin
                m_pend = 1;
                m_tgt  = bt;
            end
            m_run = st ? m_run + 1 : 0;
            if (m_run >= SMAX) m_to = 1;
        end
        #1;
    endtask

    initial begin
        logic [31:0] bt;
        reset = 1; stall = 0; br_valid = 0; exc_req = 0; eret_req = 0;
        br_target = 0; epc = 0; pc_f = RPC;
        m_pend = 0; m_tgt = 0; m_mis = 0; m_to = 0; m_run = 0;
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0, 0, 0, RPC);
        // free-run and unstalled branch
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h3000);
        cyc(0, 0, 1, 0, 0, 32'h3040, 0, 32'h3004);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h3040);
        // stalled branch held three cycles, then consumed
        cyc(0, 1, 1, 0, 0, 32'h3100, 0, 32'h3044);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h3044);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h3044);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h3044);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h3100);
        // cancel by exception, then exception beats ERET
        cyc(0, 1, 1, 0, 0, 32'h3100, 0, 32'h3104);
        cyc(0, 1, 0, 1, 0, 0, 0, 32'h3104);
        cyc(0, 0, 0, 1, 1, 0, 32'h3200, 32'h4180);
        cyc(0, 0, 0, 0, 1, 0, 32'h3200, 32'h4180);
        // watchdog: sixteen stalled edges, flag sticks afterwards
        for (int i = 0; i < SMAX; i++) cyc(0, 1, 0, 0, 0, 0, 0, 32'h3200);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h3200);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h3204);
        // misaligned redirect, wrap-around
        cyc(0, 0, 1, 0, 0, 32'h3002, 0, 32'h3208);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h3002);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        // reset while a redirect is pending
        cyc(0, 1, 1, 0, 0, 32'h3300, 0, 32'h0);
        cyc(1, 1, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h3000);
        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bt = $urandom;
            if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
            cyc($urandom_range(63) == 0, $urandom_range(9) < 6, $urandom_range(3) == 0,
                $urandom_range(15) == 0, $urandom_range(15) == 0, bt, $urandom,
                ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h3000);
        @(posedge clk); #1;
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
